// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command buffer and result register in front of a
// combinational 8-bit ALU.
//
// Commands {a, b, opcode} arrive on a valid/ready handshake and queue in a
// DEPTH-entry FIFO. The FIFO head drives the ALU inputs directly. The ALU
// output is captured, along with a zero flag and the producing opcode, into
// a single result slot that has its own valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake; cmd_ready = FIFO not full
//   cmd_a, cmd_b        command operands
//   cmd_opcode          command ALU opcode
//   alu_a, alu_b        FIFO head operands to the ALU (stale when empty)
//   alu_opcode          FIFO head opcode to the ALU
//   alu_result          combinational ALU output
//   res_valid/res_ready result slot handshake
//   res_data            captured ALU result
//   res_opcode          opcode that produced res_data
//   res_zero            res_data == 0
//   level               FIFO occupancy, 0..DEPTH
module alu_cmd_issue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_opcode,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_opcode,
  output logic             res_zero,
  output logic [PTR_W:0]   level
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned LVL_W  = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

  // FIFO storage: deliberately left without reset
  cmd_t r_mem [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [OP_W-1:0]   r_res_opcode;
  logic              r_res_zero;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_slot_free;
  cmd_t              w_wr_entry;
  cmd_t              w_head;

  // Occupancy flags come straight from the level counter
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);

  // Push depends only on full; a pop in the same cycle does not open a slot
  assign w_push = cmd_valid && !w_full;

  // Slot is free if empty or being drained this cycle
  assign w_slot_free = !r_res_valid || res_ready;
  assign w_pop       = !w_empty && w_slot_free;

  assign w_wr_entry = '{a: cmd_a, b: cmd_b, op: cmd_opcode};
  assign w_head     = r_mem[r_rd_ptr];

  // Storage write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves level unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Result slot: capture on pop, clear valid on drain without refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_opcode <= '0;
      r_res_zero   <= 1'b0;
    end else if (w_pop) begin
      r_res_valid  <= 1'b1;
      r_res_data   <= alu_result;
      r_res_opcode <= w_head.op;
      r_res_zero   <= (alu_result == '0);
    end else if (r_res_valid && res_ready) begin
      r_res_valid  <= 1'b0;
    end
  end

  // Simulation checks: history of the held result
  logic                           r_chk_hold;
  logic [DATA_W+OP_W:0]           r_chk_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_hold <= 1'b0;
      r_chk_res  <= '0;
    end else begin
      r_chk_hold <= r_res_valid && !res_ready;
      r_chk_res  <= {r_res_data, r_res_opcode, r_res_zero};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_push_full: assert (!(w_push && w_full));
      a_no_pop_empty: assert (!(w_pop && w_empty));
      if (r_chk_hold) begin
        a_res_stable: assert ({r_res_data, r_res_opcode, r_res_zero} == r_chk_res);
      end
    end
  end

  assign cmd_ready  = !w_full;
  assign alu_a      = w_head.a;
  assign alu_b      = w_head.b;
  assign alu_opcode = w_head.op;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_opcode = r_res_opcode;
  assign res_zero   = r_res_zero;
  assign level      = r_level;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Testbench for alu_cmd_issue: directed scenarios plus random traffic,
// checked against a queue-based reference model and a result scoreboard.
module tb_alu_cmd_issue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_opcode;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_opcode;
  logic [7:0]       alu_result;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [2:0]       res_opcode;
  logic             res_zero;
  logic [PTR_W:0]   level;

  alu_cmd_issue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opcode(res_opcode), .res_zero(res_zero),
    .level(level)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, sub, mul, shl, shr, and, or, xor
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] w;
    case (op)
      3'd0:    w = 16'(a) + 16'(b);
      3'd1:    w = 16'(a) - 16'(b);
      3'd2:    w = 16'(a) * 16'(b);
      3'd3:    w = 16'(a) << 1;
      3'd4:    w = 16'(a) >> 1;
      3'd5:    w = 16'(a & b);
      3'd6:    w = 16'(a | b);
      default: w = 16'(a ^ b);
    endcase
    return w[7:0];
  endfunction

  always_comb alu_result = alu_ref(alu_opcode, alu_a, alu_b);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_s;

  // Reference model state
  cmd_s       mq[$];
  logic [7:0] exp_out[$];
  logic       m_rv;
  logic [7:0] m_rd;
  logic [2:0] m_ro;
  logic       m_rz;

  int n_total = 0;
  int n_bad   = 0;
  int accepted;
  int consumed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_out.delete();
    m_rv = 1'b0;
    m_rd = 8'h00;
    m_ro = 3'b000;
    m_rz = 1'b0;
  endtask

  // One clock edge of the reference model, from the inputs the bench drives
  task automatic model_edge();
    bit   push;
    bit   pop;
    cmd_s h;
    push = cmd_valid && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && (!m_rv || res_ready);
    if (pop) begin
      h    = mq.pop_front();
      m_rd = alu_ref(h.op, h.a, h.b);
      m_ro = h.op;
      m_rz = (m_rd == 8'h00);
      m_rv = 1'b1;
    end else if (m_rv && res_ready) begin
      m_rv = 1'b0;
    end
    if (push) begin
      mq.push_back('{a: cmd_a, b: cmd_b, op: cmd_opcode});
      exp_out.push_back(alu_ref(cmd_opcode, cmd_a, cmd_b));
    end
  endtask

  task automatic check_outputs();
    chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    chk("level", 32'(level), 32'(mq.size()));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    chk("res_data", 32'(res_data), 32'(m_rd));
    chk("res_opcode", 32'(res_opcode), 32'(m_ro));
    chk("res_zero", 32'(res_zero), 32'(m_rz));
    if (mq.size() > 0) begin
      chk("alu_a", 32'(alu_a), 32'(mq[0].a));
      chk("alu_b", 32'(alu_b), 32'(mq[0].b));
      chk("alu_opcode", 32'(alu_opcode), 32'(mq[0].op));
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic rr);
    cmd_valid  = v;
    cmd_a      = a;
    cmd_b      = b;
    cmd_opcode = op;
    res_ready  = rr;
  endtask

  // Scoreboard the handshakes about to complete, run one edge, then check
  task automatic cycle();
    if (res_valid && res_ready) begin
      if (exp_out.size() == 0) begin
        chk("consume_unexpected", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        chk("consume_order", 32'(res_data), 32'(exp_out.pop_front()));
        consumed++;
      end
    end
    if (cmd_valid && cmd_ready) accepted++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int i;
    int guard;
    bit acc;

    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    model_reset();
    accepted = 0;
    consumed = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single command latency
    drive(1'b1, 8'h0F, 8'h01, 3'b000, 1'b1);
    cycle();
    chk("t1_not_yet", 32'(res_valid), 32'd0);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    cycle();
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_data", 32'(res_data), 32'h10);
    chk("t1_op", 32'(res_opcode), 32'd0);
    chk("t1_zero", 32'(res_zero), 32'd0);
    cycle();

    // Back-to-back stream
    drive(1'b1, 8'h05, 8'h07, 3'b001, 1'b1);
    cycle();
    drive(1'b1, 8'h10, 8'h10, 3'b010, 1'b1);
    cycle();
    chk("t2_r0", 32'(res_data), 32'hFE);
    drive(1'b1, 8'h81, 8'h00, 3'b011, 1'b1);
    cycle();
    chk("t2_r1", 32'(res_data), 32'h00);
    chk("t2_r1_zero", 32'(res_zero), 32'd1);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    cycle();
    chk("t2_r2", 32'(res_data), 32'h02);
    chk("t2_r2_valid", 32'(res_valid), 32'd1);
    repeat (2) cycle();

    // Stalled consumer fills slot + FIFO; commands result in i+3
    accepted = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(k + 1), 8'h02, 3'b000, 1'b0);
      cycle();
    end
    chk("t3_accepted", 32'(accepted), 32'd5);
    chk("t3_ready_low", 32'(cmd_ready), 32'd0);
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_hold", 32'(res_data), 32'h03);

    // Full with simultaneous pop: no push
    drive(1'b1, 8'hEE, 8'hEE, 3'b000, 1'b1);
    chk("t4_ready_full", 32'(cmd_ready), 32'd0);
    cycle();
    chk("t4_level", 32'(level), 32'd3);
    chk("t4_ready_back", 32'(cmd_ready), 32'd1);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    consumed = 0;
    repeat (6) cycle();
    chk("t4_drained", 32'(consumed), 32'd4);

    // Pointer wrap with toggling consumer
    i = 0;
    consumed = 0;
    guard = 0;
    while (i < 10 && guard < 100) begin
      drive(1'b1, 8'(i), 8'hFF, 3'b111, guard[0]);
      acc = (mq.size() < DEPTH);
      cycle();
      if (acc) i++;
      guard++;
    end
    chk("t5_all_sent", 32'(i), 32'd10);
    guard = 0;
    while (consumed < 10 && guard < 100) begin
      drive(1'b0, 8'h00, 8'h00, 3'b000, guard[0]);
      cycle();
      guard++;
    end
    chk("t5_consumed", 32'(consumed), 32'd10);

    // Async reset mid-stream with level 3
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h20 + k), 8'h01, 3'b000, 1'b0);
      cycle();
    end
    chk("t6_level3", 32'(level), 32'd3);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(res_valid), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    drive(1'b1, 8'h03, 8'h04, 3'b000, 1'b1);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    cycle();
    chk("t6_after", 32'(res_data), 32'h07);
    cycle();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ((k % 16) == 5) cmd_b = cmd_a;
      cycle();
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    repeat (8) cycle();
    chk("final_sb_empty", 32'(exp_out.size()), 32'd0);
    chk("final_idle", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
